// File: rtl/os_pfb_dl_pkg.sv
// rtl/os_pfb_dl_pkg.sv - shared types and constants for the os_pfb deadlock origin arbiter
package os_pfb_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_CLEAR    = 2'd2,
        ST_REPORTED = 2'd3
    } dl_state_t;

    localparam int DL_PROC_NUM = 3;

    localparam int POLYPHASE_FILTER = 0;
    localparam int FFT_CONFIG       = 1;
    localparam int BE               = 2;

    // Human-readable process name for log messages
    function automatic string proc_name(input int idx);
        case (idx)
            POLYPHASE_FILTER: return "polyphase_filter";
            FFT_CONFIG:       return "fft_os_pfb_config";
            BE:               return "be";
            default:          return "unknown";
        endcase
    endfunction

endpackage

// File: rtl/os_pfb_dl_prio_enc.sv
// rtl/os_pfb_dl_prio_enc.sv - lowest-index priority encoder, one-hot and binary outputs
module os_pfb_dl_prio_enc #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan high to low so the lowest set bit is the last one written
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/os_pfb_dl_origin_arbiter.sv
// rtl/os_pfb_dl_origin_arbiter.sv - elects a deadlock origin, broadcasts freeze, confirms or clears
module os_pfb_dl_origin_arbiter
    import os_pfb_dl_pkg::*;
#(
    parameter int PROC_NUM       = DL_PROC_NUM,
    parameter int CONFIRM_CYCLES = 16,
    parameter int ID_W           = 2,
    parameter int FA_W           = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                dl_confirmed,
    output logic [ID_W-1:0]     dl_proc_id,
    output logic                dl_report,
    output logic [FA_W-1:0]     false_alarm_cnt
);

    localparam int CNT_W = (CONFIRM_CYCLES > 2) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);

    dl_state_t           state;
    logic [CNT_W-1:0]    cnt;
    logic [ID_W-1:0]     origin_idx;
    logic [PROC_NUM-1:0] enc_onehot;
    logic [ID_W-1:0]     enc_idx;
    logic                enc_any;
    logic                origin_flag;

    os_pfb_dl_prio_enc #(
        .N  (PROC_NUM),
        .IW (ID_W)
    ) u_prio_enc (
        .req    (dl_in_vec),
        .onehot (enc_onehot),
        .idx    (enc_idx),
        .any    (enc_any)
    );

    // Only the elected origin's flag matters while holding
    assign origin_flag = |(dl_in_vec & origin);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            origin          <= '0;
            origin_idx      <= '0;
            dl_detect_out   <= 1'b0;
            token_clear     <= 1'b0;
            dl_confirmed    <= 1'b0;
            dl_proc_id      <= '0;
            dl_report       <= 1'b0;
            false_alarm_cnt <= '0;
        end else begin
            dl_report <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enc_any) begin
                        origin        <= enc_onehot;
                        origin_idx    <= enc_idx;
                        dl_detect_out <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!origin_flag) begin
                        token_clear   <= 1'b1;
                        dl_detect_out <= 1'b0;
                        origin        <= '0;
                        if (false_alarm_cnt != '1)
                            false_alarm_cnt <= false_alarm_cnt + 1'b1;
                        state         <= ST_CLEAR;
                    end else if (cnt == CNT_LAST) begin
                        dl_confirmed <= 1'b1;
                        dl_report    <= 1'b1;
                        dl_proc_id   <= origin_idx;
                        state        <= ST_REPORTED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    token_clear <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            assert ($onehot0(origin));
            assert (!(token_clear && dl_detect_out));
            if (state == ST_IDLE)
                assert (!$isunknown(dl_in_vec));
        end
    end

endmodule

// File: tb/tb_os_pfb_dl_origin_arbiter.sv
// tb/tb_os_pfb_dl_origin_arbiter.sv - randomized self-checking bench for the origin arbiter
module tb_os_pfb_dl_origin_arbiter;
    import os_pfb_dl_pkg::*;

    localparam int PROC_NUM = 3;
    localparam int CONFIRM  = 16;
    localparam int ID_W     = 2;
    localparam int FA_W     = 8;
    localparam int FA_MAX   = (1 << FA_W) - 1;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [PROC_NUM-1:0] dl_in_vec = '0;
    logic                dl_detect_out;
    logic [PROC_NUM-1:0] origin;
    logic                token_clear;
    logic                dl_confirmed;
    logic [ID_W-1:0]     dl_proc_id;
    logic                dl_report;
    logic [FA_W-1:0]     false_alarm_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: origin index (-1 none), hold cycles seen, confirmed/report/clear flags
    int m_org = -1;
    int m_hold_cycles = 0;
    bit m_conf = 0, m_rep = 0, m_tc = 0, m_det = 0;
    int m_fa = 0;
    int m_id = 0;

    always #5 clock = ~clock;

    os_pfb_dl_origin_arbiter #(
        .PROC_NUM       (PROC_NUM),
        .CONFIRM_CYCLES (CONFIRM),
        .ID_W           (ID_W),
        .FA_W           (FA_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .dl_in_vec       (dl_in_vec),
        .dl_detect_out   (dl_detect_out),
        .origin          (origin),
        .token_clear     (token_clear),
        .dl_confirmed    (dl_confirmed),
        .dl_proc_id      (dl_proc_id),
        .dl_report       (dl_report),
        .false_alarm_cnt (false_alarm_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int lowest(input logic [PROC_NUM-1:0] v);
        for (int i = 0; i < PROC_NUM; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_update(input logic rst_n, input logic [PROC_NUM-1:0] v);
        if (!rst_n) begin
            m_org = -1; m_hold_cycles = 0; m_conf = 0; m_rep = 0;
            m_tc = 0; m_det = 0; m_fa = 0; m_id = 0;
        end else if (m_conf) begin
            m_rep = 0;
        end else if (m_tc) begin
            m_tc = 0;
        end else if (m_org < 0) begin
            if (v != 0) begin
                m_org = lowest(v);
                m_det = 1;
                m_hold_cycles = 0;
            end
        end else if (!v[m_org]) begin
            m_tc = 1; m_det = 0; m_org = -1;
            if (m_fa < FA_MAX) m_fa++;
        end else begin
            m_hold_cycles++;
            if (m_hold_cycles == CONFIRM) begin
                m_conf = 1; m_rep = 1; m_id = m_org;
                $display("model: deadlock confirmed on %s", proc_name(m_org));
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic [PROC_NUM-1:0] v);
        logic [PROC_NUM-1:0] exp_org;
        @(negedge clock);
        reset = rst_n;
        dl_in_vec = v;
        @(posedge clock);
        model_update(rst_n, v);
        #1;
        exp_org = (m_org < 0) ? '0 : PROC_NUM'(1 << m_org);
        check("dl_detect_out", 32'(dl_detect_out), 32'(m_det));
        check("origin", 32'(origin), 32'(exp_org));
        check("token_clear", 32'(token_clear), 32'(m_tc));
        check("dl_confirmed", 32'(dl_confirmed), 32'(m_conf));
        check("dl_proc_id", 32'(dl_proc_id), m_conf ? 32'(m_id) : 32'd0);
        check("dl_report", 32'(dl_report), 32'(m_rep));
        check("false_alarm_cnt", 32'(false_alarm_cnt), 32'(m_fa));
    endtask

    initial begin
        int steps;
        logic [PROC_NUM-1:0] v;
        bit seen;

        // Reset state
        repeat (3) step(1'b0, 3'b111);
        check("reset_detect", 32'(dl_detect_out), 32'd0);
        check("reset_fa", 32'(false_alarm_cnt), 32'd0);

        // Single origin confirmed: report CONFIRM+1 edges after the flag is applied
        step(1'b1, 3'b000);
        step(1'b1, 3'b100);
        check("single_detect_next", 32'(dl_detect_out), 32'd1);
        check("single_origin", 32'(origin), 32'b100);
        steps = 1;
        seen = 0;
        while (!seen && steps < 40) begin
            step(1'b1, 3'b100);
            steps++;
            if (dl_report) seen = 1;
        end
        check("single_report_seen", 32'(seen), 32'd1);
        check("single_latency", steps, CONFIRM + 1);
        check("single_proc_id", 32'(dl_proc_id), 32'd2);
        repeat (4) step(1'b1, 3'($urandom));
        check("reported_sticky", 32'(dl_confirmed), 32'd1);

        // Priority: lowest index wins, then later bits are ignored
        step(1'b0, 3'b000);
        step(1'b1, 3'b110);
        check("prio_origin", 32'(origin), 32'b010);
        repeat (2) step(1'b1, 3'b110);
        repeat (CONFIRM + 2) step(1'b1, 3'b010);
        check("prio_proc_id", 32'(dl_proc_id), 32'd1);

        // False alarm, then re-trigger with bit0 held through CLEAR
        step(1'b0, 3'b000);
        repeat (4) step(1'b1, 3'b001);
        step(1'b1, 3'b000);
        check("fa_token_clear", 32'(token_clear), 32'd1);
        check("fa_detect_low", 32'(dl_detect_out), 32'd0);
        check("fa_count", 32'(false_alarm_cnt), 32'd1);
        step(1'b1, 3'b001);
        check("retrig_clear_once", 32'(token_clear), 32'd0);
        step(1'b1, 3'b001);
        check("retrig_origin", 32'(origin), 32'b001);

        // Reset mid-HOLD
        step(1'b0, 3'b000);
        repeat (5) step(1'b1, 3'b010);
        step(1'b0, 3'b010);
        check("midhold_origin", 32'(origin), 32'd0);

        // Saturation of the false-alarm counter
        for (int p = 0; p < 300; p++) begin
            step(1'b1, 3'b010);
            step(1'b1, 3'b010);
            step(1'b1, 3'b000);
            step(1'b1, 3'b000);
        end
        check("fa_saturated", 32'(false_alarm_cnt), FA_MAX);
        check("fa_no_confirm", 32'(dl_confirmed), 32'd0);

        // Randomized run with sticky inputs and occasional resets
        v = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) v = 3'($urandom);
            step(($urandom_range(299) == 0) ? 1'b0 : 1'b1, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
